// File: rtl/aer_spike_tx.sv
// AER spike transmitter: serialises post-neuron spike vectors and time-step markers
// through a FIFO onto a 4-phase REQ/ACK link.
// Ports: CLK/RST; EVT_VALID/EVT_READY with NEUR_EVENT_OUT and CTRL_POST_NEURON_ADDRESS
// capture a spike vector; CTRL_TSTEP_EVENT requests a marker; AER_ADDR/AER_REQ/AER_ACK
// form the off-chip link; FIFO_FULL/FIFO_EMPTY/DROP_CNT are status outputs.
module aer_spike_tx #(
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int POST_NEUR_ADDR_WIDTH      = 10,
  parameter int POST_NEUR_BYTE_ADDR_WIDTH = 2,
  parameter int AER_WIDTH                 = 12,
  parameter int FIFO_DEPTH                = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            EVT_VALID,
  output logic                            EVT_READY,
  input  logic [POST_NEUR_PARALLEL-1:0]   NEUR_EVENT_OUT,
  input  logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
  input  logic                            CTRL_TSTEP_EVENT,
  output logic [AER_WIDTH-1:0]            AER_ADDR,
  output logic                            AER_REQ,
  input  logic                            AER_ACK,
  output logic                            FIFO_FULL,
  output logic                            FIFO_EMPTY,
  output logic [7:0]                      DROP_CNT
);

  localparam int GW = POST_NEUR_ADDR_WIDTH - POST_NEUR_BYTE_ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = POST_NEUR_BYTE_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT_HI, WAIT_LO} state_t;

  logic [POST_NEUR_PARALLEL-1:0]   mask_q, mask_d;
  logic [GW-1:0]                   group_q, group_d;
  logic                            tstep_pend_q, tstep_pend_d;
  logic [POST_NEUR_ADDR_WIDTH-1:0] tstep_cnt_q, tstep_cnt_d;
  logic [7:0]                      drop_q, drop_d;
  logic [PW:0]                     wptr_q, wptr_d;
  logic [PW:0]                     rptr_q, rptr_d;
  logic [AER_WIDTH-1:0]            mem_q [FIFO_DEPTH];
  logic                            ack_meta_q, ack_s_q;
  state_t                          state_q;
  logic                            req_q;
  logic [AER_WIDTH-1:0]            addr_q;

  logic                 transfer;
  logic                 push_spk;
  logic                 push_mrk;
  logic                 push;
  logic                 pop;
  logic [LW-1:0]        lane;
  logic [AER_WIDTH-1:0] push_word;
  logic                 unused_lsb;

  assign unused_lsb = ^CTRL_POST_NEURON_ADDRESS[LW-1:0];

  assign EVT_READY  = (mask_q == '0);
  assign transfer   = EVT_VALID & EVT_READY;
  assign FIFO_EMPTY = (wptr_q == rptr_q);
  // Extra pointer bit distinguishes full from empty.
  assign FIFO_FULL  = (wptr_q[PW] != rptr_q[PW]) &&
                      (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

  // Lowest set lane wins.
  always_comb begin
    lane = '0;
    for (int i = POST_NEUR_PARALLEL - 1; i >= 0; i--) begin
      if (mask_q[i]) lane = LW'(i);
    end
  end

  assign push_spk = (mask_q != '0) & ~FIFO_FULL;
  // A marker waits for an idle cycle so earlier spikes stay ahead of it.
  assign push_mrk = tstep_pend_q & (mask_q == '0) & ~FIFO_FULL & ~transfer;
  assign push     = push_spk | push_mrk;
  assign pop      = (state_q == IDLE) & ~FIFO_EMPTY;

  always_comb begin
    push_word = {2'b01, tstep_cnt_q};
    if (push_spk) push_word = {2'b00, group_q, lane};
  end

  always_comb begin
    mask_d       = mask_q;
    group_d      = group_q;
    tstep_pend_d = tstep_pend_q;
    tstep_cnt_d  = tstep_cnt_q;
    drop_d       = drop_q;
    wptr_d       = wptr_q + (PW+1)'(push);
    rptr_d       = rptr_q + (PW+1)'(pop);
    if (transfer) begin
      mask_d  = NEUR_EVENT_OUT;
      group_d = CTRL_POST_NEURON_ADDRESS[POST_NEUR_ADDR_WIDTH-1:LW];
    end else if (push_spk) begin
      mask_d[lane] = 1'b0;
    end
    if (push_mrk) begin
      // A pulse coinciding with the push re-arms rather than drops.
      tstep_pend_d = CTRL_TSTEP_EVENT;
      tstep_cnt_d  = tstep_cnt_q + 1'b1;
    end else if (CTRL_TSTEP_EVENT) begin
      tstep_pend_d = 1'b1;
      if (tstep_pend_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q[PW-1:0]] <= push_word;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask_q       <= '0;
      group_q      <= '0;
      tstep_pend_q <= 1'b0;
      tstep_cnt_q  <= '0;
      drop_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
    end else begin
      mask_q       <= mask_d;
      group_q      <= group_d;
      tstep_pend_q <= tstep_pend_d;
      tstep_cnt_q  <= tstep_cnt_d;
      drop_q       <= drop_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
    end
  end

  // Output handshake FSM with ACK synchroniser; REQ/ADDR are registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      ack_meta_q <= AER_ACK;
      ack_s_q    <= ack_meta_q;
      unique case (state_q)
        IDLE: begin
          if (!FIFO_EMPTY) begin
            addr_q  <= mem_q[rptr_q[PW-1:0]];
            state_q <= SETUP;
          end
        end
        SETUP: begin
          req_q   <= 1'b1;
          state_q <= WAIT_HI;
        end
        WAIT_HI: begin
          if (ack_s_q) begin
            req_q   <= 1'b0;
            state_q <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!ack_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign AER_REQ  = req_q;
  assign AER_ADDR = addr_q;
  assign DROP_CNT = drop_q;

endmodule
